inference_scheduler: RTL and testbench
======================================

# inference_scheduler

Batch sequencer for the SNN accelerator's classification path. A host starts a batch of `NUM_IMAGES` images. For each image the block pulses `NEW_IMAGE` to the encoder and decoder, then waits for `DECODER_RDY` or a timeout. Each result `{timeout flag, image index, inferred digit}` goes into a small result FIFO that the host drains over a valid/ready stream. The block sits between the host interface and the encoder/decoder pair.

## Interface
- `M`, default 8: width of inferred digit.
- `IDX_W`, default 16: width of image count and index.
- `TIMEOUT`, default 4096: max WAIT_RDY cycles per image; legal range ≥ 2.
- `DEPTH`, default 4: result FIFO entries; power of two.

Ports:
- `CLK`, in, 1: single clock.
- `RST`, in, 1: reset, synchronous, active-high.
- `START`, in, 1: batch start pulse; sampled only in IDLE.
- `NUM_IMAGES`, in, `IDX_W`: images in batch; captured on accepted START.
- `BUSY`, out, 1: batch in progress.
- `DONE`, out, 1: one-cycle pulse when the last result is written.
- `NEW_IMAGE`, out, 1: to encoder and decoder; one-cycle pulse per image.
- `IMAGE_IDX`, out, `IDX_W`: index of the current image, 0-based.
- `DECODER_RDY`, in, 1: from decoder; sticky until the next `NEW_IMAGE`.
- `INFERED_DIGIT`, in, `M`: from decoder; stable while `DECODER_RDY` = 1.
- `RES_VALID`, out, 1: result FIFO non-empty.
- `RES_READY`, in, 1: host accepts head entry.
- `RES_DIGIT`, out, `M`: head entry digit.
- `RES_IDX`, out, `IDX_W`: head entry image index.
- `RES_TIMEOUT`, out, 1: head entry timed out.
- `TIMEOUT_CNT`, out, `IDX_W`: timeouts in current or last batch.

## Operation
- FSM states: IDLE, LAUNCH, SETTLE, WAIT_RDY, PUSH, FINISH.
- IDLE:
  - `START`=1 and `NUM_IMAGES`≠0: capture count, clear `IMAGE_IDX` and `TIMEOUT_CNT`, go to LAUNCH.
  - `START`=1 and `NUM_IMAGES`=0: clear `TIMEOUT_CNT`, go to FINISH.
  - Otherwise stay in IDLE.
- LAUNCH: `NEW_IMAGE`=1 for this single cycle, then go to SETTLE.
- SETTLE: one cycle in which `DECODER_RDY` is ignored, because it may still show the previous image's value. Clear the timer, then go to WAIT_RDY.
- WAIT_RDY: timer increments each cycle.
  - `DECODER_RDY`=1: latch `INFERED_DIGIT`, clear the timeout flag, go to PUSH.
  - Otherwise, when timer = `TIMEOUT`−1: latch digit = all ones, set the timeout flag, go to PUSH.
  - `DECODER_RDY` and timeout in the same cycle: `DECODER_RDY` wins.
- PUSH:
  - FIFO count < `DEPTH`: write `{flag, IMAGE_IDX, digit}`, and increment `TIMEOUT_CNT` if the flag is set.
  - Then, if `IMAGE_IDX` = count−1, go to FINISH; otherwise increment `IMAGE_IDX` and go to LAUNCH.
  - FIFO full: stay in PUSH with no write. The full check uses registered occupancy; a pop in the same cycle does not enable the push.
- FINISH: `DONE`=1 for this single cycle, then go to IDLE.
- `BUSY`=1 in every state except IDLE. `START` while busy is ignored.
- `TIMEOUT_CNT` saturates at all ones.
- Result FIFO is first-word fall-through:
  - Pop when `RES_VALID` && `RES_READY`.
  - When not full, a push and pop in the same cycle both occur and occupancy is unchanged.
  - FIFO contents persist across batches until drained.
- Reset: state returns to IDLE, FIFO is flushed, and all counters clear. Reset mid-batch abandons the batch with no `DONE`.

## Timing
- Reset values: `BUSY`=0, `DONE`=0, `NEW_IMAGE`=0, `IMAGE_IDX`=0, `RES_VALID`=0, `RES_DIGIT`=0, `RES_IDX`=0, `RES_TIMEOUT`=0, `TIMEOUT_CNT`=0.
- `NEW_IMAGE`, `BUSY` and `DONE` are decoded from the state register only, with no combinational path from inputs.
- `START` at cycle t gives LAUNCH (`NEW_IMAGE`=1) at t+1, SETTLE at t+2, and first WAIT_RDY at t+3.
- `DECODER_RDY` first seen in WAIT_RDY at cycle w gives PUSH at w+1. With space in the FIFO, the entry is visible (`RES_VALID`=1) at w+2.
- Next image: LAUNCH follows PUSH, so `NEW_IMAGE` pulses are at least 4 cycles apart.
- Timeout path: first WAIT_RDY cycle at t+3 with no ready gives PUSH at t+3+`TIMEOUT`.
- `DONE` is asserted the cycle after the last PUSH write. `BUSY` falls in the same cycle `DONE` falls.
- Zero-image batch: `START` at t gives `DONE` at t+1.

## Structure
- Shared package `snn_pkg`:
  - State enum `sched_state_t`.
  - Result struct `sched_result_t` with fields timeout, idx, digit.
  - Constant `DIGIT_TIMEOUT` = all ones.
- Sub-module `result_fifo`: parameterized by width and `DEPTH`. Ports: push/data_in, pop, data_out, empty, full, count. Registered pointers, and a count register with one extra bit.
- Top level holds the FSM, the timer (`$clog2(TIMEOUT)` bits), the index register and `TIMEOUT_CNT`.

## Test plan
- `NUM_IMAGES`=3, `RES_READY`=1, `DECODER_RDY` driven 10 cycles after each `NEW_IMAGE` with digits 7, 2, 9 → three `NEW_IMAGE` pulses, results (0,0,7), (0,1,2), (0,2,9), then one `DONE` pulse and `TIMEOUT_CNT`=0.
- `TIMEOUT`=16, `NUM_IMAGES`=1, `DECODER_RDY` never asserted → PUSH after exactly 16 WAIT_RDY cycles; result (1,0,8'hFF); `TIMEOUT_CNT`=1.
- `DECODER_RDY` held at 1 from the previous image before `START` → the SETTLE cycle ignores it and the digit is taken from WAIT_RDY. Also `DECODER_RDY` rising on the timeout cycle → result with flag 0.
- `RES_READY`=0, `NUM_IMAGES`=6, `DEPTH`=4 → 4 entries stored and FSM stalls in PUSH. Then `RES_READY`=1 → all 6 results arrive in order, with `DONE` only after the 6th write.
- `NUM_IMAGES`=0 → `DONE` one cycle after `START`, no `NEW_IMAGE`. Also `START` pulsed while busy → ignored.
- `RST` asserted during WAIT_RDY of image 1 → the next cycle shows `BUSY`=0 and `RES_VALID`=0, and no `DONE`. A new `START` restarts at index 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN classification-path control blocks.
package snn_pkg;

    // Batch sequencer states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_WAIT_RDY,
        S_PUSH,
        S_FINISH
    } sched_state_t;

    // Default accelerator widths: 8-bit digit, 16-bit image index.
    localparam int SNN_DIGIT_W = 8;
    localparam int SNN_IDX_W   = 16;

    // One classification result at the default widths, packed MSB first as
    // {timeout, idx, digit}. The scheduler packs its FIFO entries the same way.
    typedef struct packed {
        logic                   timeout;
        logic [SNN_IDX_W-1:0]   idx;
        logic [SNN_DIGIT_W-1:0] digit;
    } sched_result_t;

    // Digit reported for an image that timed out; sliced to the digit width.
    localparam logic [63:0] DIGIT_TIMEOUT = '1;

endpackage

// File: rtl/result_fifo.sv
// First-word fall-through result FIFO with registered pointers and occupancy.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   pop,
    output logic [WIDTH-1:0]       data_out,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head entry is presented directly; forced to zero while empty.
    assign data_out = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because occupancy gates the read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inference_scheduler.sv
// Batch sequencer: launches each image, waits for the decoder or a timeout,
// and queues {timeout, index, digit} results for the host.
module inference_scheduler
    import snn_pkg::*;
#(
    parameter int M       = 8,
    parameter int IDX_W   = 16,
    parameter int TIMEOUT = 4096,
    parameter int DEPTH   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [IDX_W-1:0] NUM_IMAGES,
    output logic             BUSY,
    output logic             DONE,
    output logic             NEW_IMAGE,
    output logic [IDX_W-1:0] IMAGE_IDX,
    input  logic             DECODER_RDY,
    input  logic [M-1:0]     INFERED_DIGIT,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [M-1:0]     RES_DIGIT,
    output logic [IDX_W-1:0] RES_IDX,
    output logic             RES_TIMEOUT,
    output logic [IDX_W-1:0] TIMEOUT_CNT
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Same field order as sched_result_t, at this instance's widths.
    typedef struct packed {
        logic             timeout;
        logic [IDX_W-1:0] idx;
        logic [M-1:0]     digit;
    } result_t;

    localparam int RES_W = $bits(result_t);

    sched_state_t     state;
    logic             busy;
    logic             done;
    logic             new_image;
    logic [IDX_W-1:0] image_idx;
    logic [IDX_W-1:0] num_images_q;
    logic [IDX_W-1:0] timeout_cnt;
    logic [TMR_W-1:0] timer;
    logic [M-1:0]     digit_q;
    logic             flag_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count_unused;
    logic [RES_W-1:0] head_bits;
    result_t          push_entry;
    result_t          head_entry;

    assign push_entry = {flag_q, image_idx, digit_q};
    assign head_entry = head_bits;

    // The full flag comes from registered occupancy, so a pop in the same
    // cycle never lets a stalled PUSH write early.
    assign fifo_push = (state == S_PUSH) && !fifo_full;
    assign fifo_pop  = RES_VALID && RES_READY;

    result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (fifo_push),
        .data_in  (push_entry),
        .pop      (fifo_pop),
        .data_out (head_bits),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count_unused)
    );

    assign BUSY        = busy;
    assign DONE        = done;
    assign NEW_IMAGE   = new_image;
    assign IMAGE_IDX   = image_idx;
    assign TIMEOUT_CNT = timeout_cnt;
    assign RES_VALID   = !fifo_empty;
    assign RES_DIGIT   = head_entry.digit;
    assign RES_IDX     = head_entry.idx;
    assign RES_TIMEOUT = head_entry.timeout;

    // Sequencer FSM; BUSY/DONE/NEW_IMAGE are registered alongside the state
    // transition so they track the state register with no input path.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            new_image    <= 1'b0;
            image_idx    <= '0;
            num_images_q <= '0;
            timeout_cnt  <= '0;
            timer        <= '0;
            digit_q      <= '0;
            flag_q       <= 1'b0;
        end else begin
            done      <= 1'b0;
            new_image <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        busy        <= 1'b1;
                        timeout_cnt <= '0;
                        if (NUM_IMAGES != '0) begin
                            num_images_q <= NUM_IMAGES;
                            image_idx    <= '0;
                            new_image    <= 1'b1;
                            state        <= S_LAUNCH;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    timer <= '0;
                    state <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    timer <= timer + 1'b1;
                    if (DECODER_RDY) begin
                        digit_q <= INFERED_DIGIT;
                        flag_q  <= 1'b0;
                        state   <= S_PUSH;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        digit_q <= DIGIT_TIMEOUT[M-1:0];
                        flag_q  <= 1'b1;
                        state   <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (!fifo_full) begin
                        if (flag_q && (timeout_cnt != '1)) begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                        end
                        if (image_idx == num_images_q - 1'b1) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            image_idx <= image_idx + 1'b1;
                            new_image <= 1'b1;
                            state     <= S_LAUNCH;
                        end
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inference_scheduler.sv
// Self-checking bench for inference_scheduler with a behavioural decoder,
// a host that drains results, and an expected-result queue per batch.
module tb_inference_scheduler;
    import snn_pkg::*;

    localparam int M       = 8;
    localparam int IDX_W   = 16;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic [IDX_W-1:0] NUM_IMAGES;
    logic             BUSY;
    logic             DONE;
    logic             NEW_IMAGE;
    logic [IDX_W-1:0] IMAGE_IDX;
    logic             DECODER_RDY;
    logic [M-1:0]     INFERED_DIGIT;
    logic             RES_VALID;
    logic             RES_READY;
    logic [M-1:0]     RES_DIGIT;
    logic [IDX_W-1:0] RES_IDX;
    logic             RES_TIMEOUT;
    logic [IDX_W-1:0] TIMEOUT_CNT;

    always #5 CLK = ~CLK;

    inference_scheduler #(
        .M       (M),
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .START         (START),
        .NUM_IMAGES    (NUM_IMAGES),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .NEW_IMAGE     (NEW_IMAGE),
        .IMAGE_IDX     (IMAGE_IDX),
        .DECODER_RDY   (DECODER_RDY),
        .INFERED_DIGIT (INFERED_DIGIT),
        .RES_VALID     (RES_VALID),
        .RES_READY     (RES_READY),
        .RES_DIGIT     (RES_DIGIT),
        .RES_IDX       (RES_IDX),
        .RES_TIMEOUT   (RES_TIMEOUT),
        .TIMEOUT_CNT   (TIMEOUT_CNT)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Per-image decoder behaviour: ready rises `delays[i]` cycles after the
    // NEW_IMAGE cycle with digit `digits[i]`.
    int delays [16];
    int digits [16];

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Ready is seen in time if it rises no later than the last waiting cycle:
    // waiting spans ages 2 .. TIMEOUT+1 after the NEW_IMAGE cycle.
    function automatic bit in_time(input int d);
        return d <= TIMEOUT + 1;
    endfunction

    function automatic int wait_cycles(input int d);
        return in_time(d) ? d - 1 : TIMEOUT;
    endfunction

    function automatic sched_result_t exp_result(input int i);
        sched_result_t r;
        r.timeout = !in_time(delays[i]);
        r.idx     = IDX_W'(i);
        r.digit   = in_time(delays[i]) ? 8'(digits[i]) : 8'hFF;
        return r;
    endfunction

    // ready_mode: 0 always ready, 1 random, 2 held low until release_at.
    task automatic run_batch(input int n, input int ready_mode, input int release_at,
                             input bit chk_timing, input int poke_at, input bit poke_on_done);
        sched_result_t exp_q[$];
        sched_result_t got;
        sched_result_t want;
        int exp_tcnt    = 0;
        int launches    = 0;
        int dones       = 0;
        int received    = 0;
        int age         = 0;
        int cur         = -1;
        int last_launch = 0;
        int expect_cyc  = 0;
        int c0;
        bit done_seen   = 0;
        bit busy_bad    = 0;
        bit finished    = 0;
        for (int i = 0; i < n; i++) begin
            want = exp_result(i);
            exp_q.push_back(want);
            if (want.timeout) exp_tcnt++;
        end
        c0 = cyc;
        NUM_IMAGES = IDX_W'(n);
        START = 1'b1;
        tick();
        START = 1'b0;
        // The count must have been captured; a later change must not matter.
        NUM_IMAGES = IDX_W'(n + 3);
        for (int budget = 0; budget < 3000; budget++) begin
            if (BUSY !== !done_seen) busy_bad = 1;
            if (NEW_IMAGE === 1'b1) begin
                launches++;
                tests++;
                if (IMAGE_IDX !== IDX_W'(launches - 1)) begin
                    fails++;
                    $display("FAIL image_idx: got %0d expected %0d", IMAGE_IDX, launches - 1);
                end
                if (chk_timing) begin
                    expect_cyc = (launches == 1) ? c0 + 1
                                 : last_launch + 3 + wait_cycles(delays[launches - 2]);
                    tests++;
                    if (cyc != expect_cyc) begin
                        fails++;
                        $display("FAIL launch_time: image %0d at cycle %0d expected %0d",
                                 launches - 1, cyc, expect_cyc);
                    end
                end
                last_launch = cyc;
                cur = launches - 1;
                age = 0;
            end else begin
                age++;
            end
            if (DONE === 1'b1) begin
                dones++;
                tests++;
                if (TIMEOUT_CNT !== IDX_W'(exp_tcnt)) begin
                    fails++;
                    $display("FAIL timeout_cnt: got %0d expected %0d", TIMEOUT_CNT, exp_tcnt);
                end
                tests++;
                if (launches != n) begin
                    fails++;
                    $display("FAIL done_early: done after %0d launches expected %0d", launches, n);
                end
                if (chk_timing) begin
                    expect_cyc = last_launch + 3 + wait_cycles(delays[n - 1]);
                    tests++;
                    if (cyc != expect_cyc) begin
                        fails++;
                        $display("FAIL done_time: got cycle %0d expected %0d", cyc, expect_cyc);
                    end
                end
                done_seen = 1;
            end
            // Decoder: keeps the previous image's outputs for two cycles after
            // NEW_IMAGE (its response latency), then reports the new image.
            if (cur >= 0 && age >= 2) begin
                if (age >= delays[cur]) begin
                    DECODER_RDY   = 1'b1;
                    INFERED_DIGIT = 8'(digits[cur]);
                end else begin
                    DECODER_RDY   = 1'b0;
                    INFERED_DIGIT = 8'($urandom);
                end
            end
            case (ready_mode)
                0:       RES_READY = 1'b1;
                1:       RES_READY = 1'($urandom_range(0, 1));
                default: RES_READY = (cyc - c0 >= release_at);
            endcase
            if (ready_mode == 2 && cyc - c0 == release_at - 1) begin
                tests++;
                if (launches != ((n < DEPTH + 1) ? n : DEPTH + 1)) begin
                    fails++;
                    $display("FAIL stall_launches: got %0d expected %0d", launches,
                             (n < DEPTH + 1) ? n : DEPTH + 1);
                end
                tests++;
                if (dones != 0 || BUSY !== 1'b1) begin
                    fails++;
                    $display("FAIL stall_busy: dones %0d busy %b expected 0 and 1", dones, BUSY);
                end
                tests++;
                got.timeout = RES_TIMEOUT;
                got.idx     = RES_IDX;
                got.digit   = RES_DIGIT;
                if (RES_VALID !== 1'b1 || got !== exp_q[0]) begin
                    fails++;
                    $display("FAIL stall_head: valid %b entry %h expected 1 and %h",
                             RES_VALID, got, exp_q[0]);
                end
            end
            if (RES_VALID === 1'b1 && RES_READY === 1'b1) begin
                got.timeout = RES_TIMEOUT;
                got.idx     = RES_IDX;
                got.digit   = RES_DIGIT;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL result_extra: got %h expected nothing", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        fails++;
                        $display("FAIL result: got t=%0d i=%0d d=%0d expected t=%0d i=%0d d=%0d",
                                 got.timeout, got.idx, got.digit,
                                 want.timeout, want.idx, want.digit);
                    end
                end
                received++;
            end
            START = (poke_at > 0 && cyc - c0 == poke_at) || (poke_on_done && DONE === 1'b1);
            if (done_seen && received >= n) begin
                finished = 1;
                break;
            end
            tick();
        end
        tick();
        START = 1'b0;
        tests++;
        if (!finished || dones != 1 || received != n || launches != n) begin
            fails++;
            $display("FAIL batch_end: finished %0d dones %0d received %0d launches %0d expected 1 1 %0d %0d",
                     finished, dones, received, launches, n, n);
        end
        tests++;
        if (busy_bad) begin
            fails++;
            $display("FAIL busy_track: BUSY differed from in-batch status, expected 1 until DONE");
        end
        tests++;
        if (BUSY !== 1'b0 || NEW_IMAGE !== 1'b0 || RES_VALID !== 1'b0) begin
            fails++;
            $display("FAIL post_batch: busy %b new_image %b valid %b expected 0 0 0",
                     BUSY, NEW_IMAGE, RES_VALID);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        START = 1'b0;
        NUM_IMAGES = '0;
        DECODER_RDY = 1'b0;
        INFERED_DIGIT = '0;
        RES_READY = 1'b0;
        repeat (3) tick();
        tests++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || NEW_IMAGE !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: busy %b done %b new_image %b expected 0", BUSY, DONE, NEW_IMAGE);
        end
        tests++;
        if (IMAGE_IDX !== '0 || TIMEOUT_CNT !== '0) begin
            fails++;
            $display("FAIL reset_cnt: idx %0d tcnt %0d expected 0", IMAGE_IDX, TIMEOUT_CNT);
        end
        tests++;
        if (RES_VALID !== 1'b0 || RES_DIGIT !== '0 || RES_IDX !== '0 || RES_TIMEOUT !== 1'b0) begin
            fails++;
            $display("FAIL reset_res: valid %b digit %0d idx %0d to %b expected 0",
                     RES_VALID, RES_DIGIT, RES_IDX, RES_TIMEOUT);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        delays[0] = 10; digits[0] = 7;
        delays[1] = 10; digits[1] = 2;
        delays[2] = 10; digits[2] = 9;
        run_batch(3, 0, 0, 1, 0, 0);
    endtask

    task automatic test_timeout();
        delays[0] = 255; digits[0] = 0;
        run_batch(1, 0, 0, 1, 0, 0);
    endtask

    task automatic test_stale_ready();
        DECODER_RDY = 1'b1;
        INFERED_DIGIT = 8'h55;
        repeat (2) tick();
        delays[0] = 6;           digits[0] = 8'h33;
        delays[1] = TIMEOUT + 1; digits[1] = 8'h44;
        delays[2] = TIMEOUT + 2; digits[2] = 8'h66;
        run_batch(3, 0, 0, 1, 0, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 6; i++) begin
            delays[i] = 4;
            digits[i] = int'($urandom_range(0, 255));
        end
        run_batch(6, 2, 150, 0, 0, 0);
    endtask

    task automatic test_zero_images();
        NUM_IMAGES = '0;
        START = 1'b1;
        tick();
        START = 1'b0;
        tests++;
        if (DONE !== 1'b1 || BUSY !== 1'b1 || NEW_IMAGE !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: done %b busy %b new_image %b expected 1 1 0", DONE, BUSY, NEW_IMAGE);
        end
        tick();
        tests++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || NEW_IMAGE !== 1'b0 || TIMEOUT_CNT !== '0) begin
            fails++;
            $display("FAIL zero_after: done %b busy %b new_image %b tcnt %0d expected 0",
                     DONE, BUSY, NEW_IMAGE, TIMEOUT_CNT);
        end
    endtask

    task automatic test_start_while_busy();
        for (int i = 0; i < 3; i++) begin
            delays[i] = int'($urandom_range(2, 12));
            digits[i] = int'($urandom_range(0, 255));
        end
        run_batch(3, 0, 0, 1, 5, 1);
    endtask

    task automatic test_reset_midbatch();
        int seen = 0;
        int k = 0;
        bit bad = 0;
        DECODER_RDY = 1'b0;
        RES_READY = 1'b0;
        NUM_IMAGES = IDX_W'(3);
        START = 1'b1;
        tick();
        START = 1'b0;
        while (seen < 2 && k < 200) begin
            if (NEW_IMAGE === 1'b1) seen++;
            if (seen < 2) begin
                tick();
                k++;
            end
        end
        tests++;
        if (seen != 2 || IMAGE_IDX !== IDX_W'(1)) begin
            fails++;
            $display("FAIL rst_setup: launches %0d idx %0d expected 2 and 1", seen, IMAGE_IDX);
        end
        repeat (4) tick();
        tests++;
        if (RES_VALID !== 1'b1 || TIMEOUT_CNT !== IDX_W'(1)) begin
            fails++;
            $display("FAIL rst_pre: valid %b tcnt %0d expected 1 and 1", RES_VALID, TIMEOUT_CNT);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tests++;
        if (BUSY !== 1'b0 || RES_VALID !== 1'b0 || DONE !== 1'b0 ||
            IMAGE_IDX !== '0 || TIMEOUT_CNT !== '0) begin
            fails++;
            $display("FAIL rst_mid: busy %b valid %b done %b idx %0d tcnt %0d expected all 0",
                     BUSY, RES_VALID, DONE, IMAGE_IDX, TIMEOUT_CNT);
        end
        repeat (40) begin
            tick();
            if (DONE === 1'b1 || NEW_IMAGE === 1'b1 || BUSY === 1'b1) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL rst_quiet: activity after reset, expected none");
        end
        for (int i = 0; i < 2; i++) begin
            delays[i] = int'($urandom_range(2, 12));
            digits[i] = int'($urandom_range(0, 255));
        end
        run_batch(2, 0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        int n;
        for (int b = 0; b < 4; b++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                delays[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TIMEOUT + 2, 30))
                                                        : int'($urandom_range(2, TIMEOUT + 1));
                digits[i] = int'($urandom_range(0, 255));
            end
            run_batch(n, 1, 0, 0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_stale_ready();
        test_backpressure();
        test_zero_images();
        test_start_while_busy();
        test_reset_midbatch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
